serial_adder_32: RTL
====================

Name: serial_adder_32

Overview:
- Bit-serial add/subtract unit; the sequencing stage that feeds a single full_adder_1 slice one operand bit pair per cycle and consumes its carry_out through a carry flop.
- Serves as the area-minimal adder option for the ALU datapath: WIDTH-cycle latency, start/done handshake toward the ALU controller.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start_in  input  1  request; accepted only when ready_out=1
- subtract_in  input  1  sampled with start_in; 0=A+B, 1=A-B
- operand_a_in  input  WIDTH  first operand, sampled on accepted start
- operand_b_in  input  WIDTH  second operand, sampled on accepted start
- ready_out  output  1  high in IDLE and DONE
- busy_out  output  1  high in BUSY
- done_out  output  1  one-cycle pulse: result valid
- result_out  output  WIDTH  sum/difference; held until next completion
- carry_out  output  1  final carry; for subtract, 1 = no borrow
- overflow_out  output  1  signed overflow (present only with macro)

Behaviour:
- Reset values: state=IDLE, ready_out=1, busy_out=0, done_out=0, result_out=0, carry_out=0, overflow_out=0, internal shift regs/counter=0.
- FSM: IDLE -> BUSY on start_in&ready_out; BUSY -> DONE when bit counter reaches WIDTH-1 (last bit processed); DONE -> BUSY on start_in, else DONE -> IDLE.
- Accept (edge 0): latch a_sh=A, b_sh=(subtract ? ~B : B), carry flop=subtract_in, counter=0.
- BUSY, each edge: slice inputs = a_sh[0], b_sh[0], carry flop; sum bit shifted into MSB of res_sh (shift right); a_sh, b_sh shift right; carry flop <= slice carry_out; counter++.
- Latency: start at edge 0 -> bits processed at edges 1..WIDTH -> DONE entered at edge WIDTH; done_out high exactly that one cycle; result_out/carry_out updated at edge WIDTH.
- start_in while BUSY: ignored, no effect on operands or counter.
- start_in in DONE: accepted (back-to-back); done_out still pulses that cycle; state goes straight to BUSY.
- Wrap-around: result is modulo 2^WIDTH; carry_out holds bit WIDTH.
- Reset mid-operation: abort, return to IDLE, outputs to reset values, no done_out pulse.
- Counter width: $clog2(WIDTH).

Optional Feature:
- Macro: SERIAL_ADDER_OVERFLOW_EN.
- Defined: overflow_out port exists; carry into MSB captured at the final BUSY step; overflow_out = carry_in_msb ^ carry_out, updated with result_out, reset 0.
- Undefined: port and capture logic absent; all other behaviour identical.

Decomposition:
- Package serial_adder_pkg: state enum typedef (IDLE, BUSY, DONE), SERIAL_ADDER_DEFAULT_WIDTH=32 constant.
- One sub-module: full_adder_1 instantiated as the bit slice; all sequencing stays in serial_adder_32.

Test Plan:
- add 0x00000005+0x00000003, start at edge 0 -> done_out high only in cycle after edge 32, result_out=0x00000008, carry_out=0.
- add 0xFFFFFFFF+0x00000001 -> result_out=0x00000000, carry_out=1 (with macro: overflow_out=0).
- subtract 0x00000003-0x00000005 -> result_out=0xFFFFFFFE, carry_out=0 (borrow).
- with macro: add 0x7FFFFFFF+0x00000001 -> result_out=0x80000000, overflow_out=1, carry_out=0.
- start_in pulsed at edge 5 of BUSY with different operands -> ignored; first result unchanged; reset asserted at edge 10 of a new op -> ready_out=1, result_out=0, no done_out.
- start_in asserted in the DONE cycle with 0x00000010+0x00000020 -> first done pulse seen, second done 32 cycles later, result_out=0x00000030.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SERIAL_ADDER_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/serial_adder_full_adder_1.sv
// Single-bit full adder: the one arithmetic slice the serial adder reuses.
module full_adder_1 (
   input  logic a,
   input  logic b,
   input  logic carry_in,
   output logic sum,
   output logic carry_out
);

   assign sum       = a ^ b ^ carry_in;
   assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder_32.sv
// Bit-serial add/subtract, one bit pair per cycle, start/done handshake.
// Define SERIAL_ADDER_OVERFLOW_EN to add the signed overflow_out port.
module serial_adder_32
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_in,
   input  logic             subtract_in,
   input  logic [WIDTH-1:0] operand_a_in,
   input  logic [WIDTH-1:0] operand_b_in,
   output logic             ready_out,
   output logic             busy_out,
   output logic             done_out,
   output logic [WIDTH-1:0] result_out,
`ifdef SERIAL_ADDER_OVERFLOW_EN
   output logic             overflow_out,
`endif
   output logic             carry_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-2:0] res_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             slice_sum;
   logic             slice_co;
   logic [WIDTH-1:0] res_nxt;

   full_adder_1 u_slice (
      .a         (a_sh[0]),
      .b         (b_sh[0]),
      .carry_in  (carry),
      .sum       (slice_sum),
      .carry_out (slice_co)
   );

   // New sum bit enters at the MSB; after WIDTH steps the word is aligned.
   assign res_nxt = {slice_sum, res_sh};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         ready_out  <= 1'b1;
         busy_out   <= 1'b0;
         done_out   <= 1'b0;
         result_out <= '0;
         carry_out  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
         overflow_out <= 1'b0;
`endif
         a_sh       <= '0;
         b_sh       <= '0;
         res_sh     <= '0;
         carry      <= 1'b0;
         cnt        <= '0;
      end else begin
         done_out <= 1'b0;
         unique case (state)
            BUSY: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_nxt[WIDTH-1:1];
               carry  <= slice_co;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state      <= DONE;
                  ready_out  <= 1'b1;
                  busy_out   <= 1'b0;
                  done_out   <= 1'b1;
                  result_out <= res_nxt;
                  carry_out  <= slice_co;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                  // carry still holds the carry into the MSB here
                  overflow_out <= carry ^ slice_co;
`endif
               end
            end
            default: begin
               if (start_in) begin
                  state     <= BUSY;
                  ready_out <= 1'b0;
                  busy_out  <= 1'b1;
                  a_sh      <= operand_a_in;
                  b_sh      <= subtract_in ? ~operand_b_in
                                           : operand_b_in;
                  carry     <= subtract_in;
                  cnt       <= '0;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
